// File: rtl/clock_pkg.sv
// Shared types and constants for the clock's keypad front end: scan classes,
// debounce states, matrix geometry and the key codes the alarm logic decodes.
package clock_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_SINGLE,
    SCAN_MULTI
  } scan_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAND,
    ST_PRESSED
  } deb_state_e;

  localparam logic [3:0] KEY_HOUR_UP  = 4'd0;
  localparam logic [3:0] KEY_MIN_UP   = 4'd1;
  localparam logic [3:0] KEY_ALARM    = 4'd2;
  localparam logic [3:0] KEY_SNOOZE   = 4'd3;
  localparam logic [3:0] KEY_SET_TIME = 4'd4;

  // Key code is row_index*4 + col_index.
  function automatic logic [3:0] key_code_of(logic [1:0] row_index, logic [1:0] col_index);
    return {row_index, col_index};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the cleaned key-event outputs of keypad_scanner.
interface keypad_scanner_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (input col, output row, key_code, key_valid, key_held);
  modport slave  (output col, input row, key_code, key_valid, key_held);
endinterface

// File: rtl/key_debounce.sv
// Debounce FSM: turns one classified result per full scan into single-cycle
// key events with press acceptance and release tracking.
module key_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_strobe,
  input  scan_class_e scan_class,
  input  logic [3:0]  scan_code,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  deb_state_e    state;
  logic [3:0]    cand;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cand      <= '0;
      cnt       <= '0;
      rel       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_strobe) begin
        case (state)
          ST_IDLE: begin
            if (scan_class == SCAN_SINGLE) begin
              cand <= scan_code;
              cnt  <= CW'(1);
              if (DEBOUNCE_SCANS == 1) begin
                state     <= ST_PRESSED;
                key_code  <= scan_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                rel       <= '0;
              end else begin
                state <= ST_CAND;
              end
            end
          end
          ST_CAND: begin
            if (scan_class == SCAN_SINGLE && scan_code == cand) begin
              if (int'(cnt) + 1 >= DEBOUNCE_SCANS) begin
                state     <= ST_PRESSED;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                rel       <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else if (scan_class == SCAN_SINGLE) begin
              cand <= scan_code;
              cnt  <= CW'(1);
            end else begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          end
          ST_PRESSED: begin
            // Any key activity restarts the release count; no rollover.
            if (scan_class == SCAN_NONE) begin
              if (int'(rel) + 1 >= DEBOUNCE_SCANS) begin
                state    <= ST_IDLE;
                key_held <= 1'b0;
                rel      <= '0;
                cnt      <= '0;
              end else begin
                rel <= rel + 1'b1;
              end
            end else begin
              rel <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low row per slot, samples the
// synchronized columns, classifies each full scan and hands it to key_debounce.
module keypad_scanner
  import clock_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic              CP,
  input logic              _CR,
  keypad_scanner_if.master kp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(KP_ROWS * KP_COLS + 1);

  logic [3:0]    col_meta, col_s;
  logic [PW-1:0] presc;
  logic [1:0]    row_idx;
  logic [AW-1:0] acc_cnt;
  logic [3:0]    acc_code;
  logic [2:0]    slot_cnt;
  logic [3:0]    slot_code;
  logic [AW-1:0] scan_cnt;
  logic [3:0]    scan_code;
  logic          tick, scan_done;
  scan_class_e   scan_class;

  assign tick      = (presc == PW'(SCAN_DIV - 1));
  assign scan_done = tick && (row_idx == 2'd3);
  assign kp.row    = ~(4'b0001 << row_idx);

  // NOTE: blocking assignments are correct here; this block is combinational
  // and each loop iteration must see the previous iteration's count.
  always_comb begin
    slot_cnt  = '0;
    slot_code = '0;
    for (int c = 0; c < KP_COLS; c++) begin
      if (!col_s[c]) begin
        slot_cnt  = slot_cnt + 1'b1;
        slot_code = key_code_of(row_idx, 2'(c));
      end
    end
  end

  assign scan_cnt  = acc_cnt + AW'(slot_cnt);
  assign scan_code = (slot_cnt != '0) ? slot_code : acc_code;

  always_comb begin
    scan_class = SCAN_MULTI;
    if (scan_cnt == '0)             scan_class = SCAN_NONE;
    else if (scan_cnt == AW'(1))    scan_class = SCAN_SINGLE;
  end

  // NOTE: synchronizer flops reset to all-ones so an idle (pulled-up) keypad
  // never looks pressed in the first cycles after reset.
  always_ff @(posedge CP or negedge _CR) begin
    if (!_CR) begin
      col_meta <= 4'hF;
      col_s    <= 4'hF;
      presc    <= '0;
      row_idx  <= '0;
      acc_cnt  <= '0;
      acc_code <= '0;
    end else begin
      col_meta <= kp.col;
      col_s    <= col_meta;
      presc    <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        row_idx <= row_idx + 1'b1;
        if (scan_done) begin
          acc_cnt  <= '0;
          acc_code <= '0;
        end else begin
          acc_cnt  <= scan_cnt;
          acc_code <= scan_code;
        end
      end
    end
  end

  key_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk        (CP),
    .rst_n      (_CR),
    .scan_strobe(scan_done),
    .scan_class (scan_class),
    .scan_code  (scan_code),
    .key_code   (kp.key_code),
    .key_valid  (kp.key_valid),
    .key_held   (kp.key_held)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3:
// directed scan table, a hand-written reset sequence and randomized scans.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DS = 3;
  localparam int SCAN_CYC = 4 * SD;

  logic        CP;
  logic        _CR;
  logic [15:0] pressed;
  logic [3:0]  col_drv;
  int          n_pass;
  int          n_checks;

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .CP (CP),
    ._CR(_CR),
    .kp (kp)
  );

  // Physical keypad: a pressed key shorts its column low while its row is driven.
  always_comb begin
    col_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kp.row[r] && pressed[r*4+c]) col_drv[c] = 1'b0;
  end
  assign kp.col = col_drv;

  initial CP = 1'b0;
  always #5 CP = ~CP;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One full scan with a fixed key set. Returns outputs sampled after the
  // row-3 tick that closes the scan; also checks row sequencing and that no
  // pulse appears elsewhere in the scan.
  task automatic run_scan(input logic [15:0] mask, output logic v_end,
                          output logic held_end, output logic [3:0] code_end);
    int early;
    logic [3:0] exp_row;
    pressed = mask;
    early = 0;
    for (int c = 1; c <= SCAN_CYC; c++) begin
      @(posedge CP);
      @(negedge CP);
      exp_row = ~(4'b0001 << ((c / SD) % 4));
      check($sformatf("row_c%0d", c), 32'(kp.row), 32'(exp_row));
      if (c < SCAN_CYC && kp.key_valid) early++;
    end
    check("valid_mid_scan", 32'(early), 32'd0);
    v_end    = kp.key_valid;
    held_end = kp.key_held;
    code_end = kp.key_code;
  endtask

  task automatic do_reset();
    @(negedge CP);
    _CR = 1'b0;
    repeat (2) @(negedge CP);
    _CR = 1'b1;
  endtask

  // Reference model: scan history plus the index of the last accept/release.
  int         res[$];
  int         last_evt;
  bit         m_held;
  logic [3:0] m_code;

  function automatic int classify(input logic [15:0] m);
    if ($countones(m) == 0) return -1;
    if ($countones(m) > 1) return -2;
    for (int k = 0; k < 16; k++) if (m[k]) return k;
    return -2;
  endfunction

  task automatic model_reset();
    res.delete();
    last_evt = -1;
    m_held   = 1'b0;
    m_code   = 4'd0;
  endtask

  // A press is accepted when the last DS scans since the previous event all
  // saw the same lone key; a release when the last DS scans were all empty.
  task automatic model_step(input logic [15:0] m, output bit acc);
    int r, n;
    bit all;
    r = classify(m);
    res.push_back(r);
    n = res.size() - 1;
    acc = 1'b0;
    all = (n - last_evt >= DS);
    if (all)
      for (int i = 0; i < DS; i++)
        if (m_held ? (res[n-i] != -1) : (res[n-i] != r || r < 0)) all = 1'b0;
    if (!m_held && all) begin
      acc = 1'b1; m_held = 1'b1; m_code = 4'(r); last_evt = n;
    end else if (m_held && all) begin
      m_held = 1'b0; last_evt = n;
    end
  endtask

  typedef struct {
    logic [15:0] mask;
    logic        valid;
    logic [3:0]  code;
    logic        held;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [15:0] mask, input int reps, input logic [3:0] code,
                     input logic held_last, input logic valid_last);
    for (int i = 0; i < reps; i++) begin
      vec_t v;
      v.mask  = mask;
      v.code  = code;
      v.valid = (i == reps - 1) ? valid_last : 1'b0;
      v.held  = (i == reps - 1) ? held_last : vecs[$].held;
      vecs.push_back(v);
    end
  endtask

  initial begin
    logic       v, h;
    logic [3:0] k;
    logic [15:0] mask, prev;
    bit         acc;

    n_pass = 0; n_checks = 0;
    pressed = '0;
    _CR = 1'b0;
    repeat (2) @(negedge CP);
    check("reset_row", 32'(kp.row), 32'hE);
    check("reset_code", 32'(kp.key_code), 32'd0);
    check("reset_valid", 32'(kp.key_valid), 32'd0);
    check("reset_held", 32'(kp.key_held), 32'd0);
    _CR = 1'b1;

    // mask, scans, code, held after last scan, valid after last scan
    vecs.push_back('{16'h0, 1'b0, 4'd0, 1'b0});
    add(16'h0,     1, 4'd0, 1'b0, 1'b0);
    add(16'h0200,  2, 4'd0, 1'b0, 1'b0);   // key 9, first two scans
    add(16'h0200,  1, 4'd9, 1'b1, 1'b1);   // accepted on the third
    add(16'h0200,  2, 4'd9, 1'b1, 1'b0);
    add(16'h0000,  2, 4'd9, 1'b1, 1'b0);
    add(16'h0000,  1, 4'd9, 1'b0, 1'b0);   // third empty scan releases
    for (int i = 0; i < 3; i++) begin      // bouncing key 5
      add(16'h0020, 1, 4'd9, 1'b0, 1'b0);
      add(16'h0000, 1, 4'd9, 1'b0, 1'b0);
    end
    add(16'h1001,  5, 4'd9, 1'b0, 1'b0);   // keys 0 and 12: MULTI
    add(16'h0001,  2, 4'd9, 1'b0, 1'b0);
    add(16'h0001,  1, 4'd0, 1'b1, 1'b1);
    add(16'h0000,  2, 4'd0, 1'b1, 1'b0);
    add(16'h0000,  1, 4'd0, 1'b0, 1'b0);
    add(16'h0200,  2, 4'd0, 1'b0, 1'b0);
    add(16'h0200,  1, 4'd9, 1'b1, 1'b1);
    add(16'h0210,  2, 4'd9, 1'b1, 1'b0);   // key 4 joins key 9
    add(16'h0010,  2, 4'd9, 1'b1, 1'b0);   // key 9 lifted, no rollover
    add(16'h0000,  2, 4'd9, 1'b1, 1'b0);
    add(16'h0000,  1, 4'd9, 1'b0, 1'b0);
    add(16'h0010,  2, 4'd9, 1'b0, 1'b0);
    add(16'h0010,  1, 4'd4, 1'b1, 1'b1);
    add(16'h0000,  2, 4'd4, 1'b1, 1'b0);
    add(16'h0000,  1, 4'd4, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_scan(vecs[i].mask, v, h, k);
      check($sformatf("vec%0d_valid", i), 32'(v), 32'(vecs[i].valid));
      check($sformatf("vec%0d_held", i), 32'(h), 32'(vecs[i].held));
      check($sformatf("vec%0d_code", i), 32'(k), 32'(vecs[i].code));
    end

    // Reset during the second debounce scan of key 7.
    run_scan(16'h0080, v, h, k);
    check("k7_scan1_valid", 32'(v), 32'd0);
    pressed = 16'h0080;
    repeat (6) @(posedge CP);
    @(negedge CP);
    _CR = 1'b0;
    #1;
    check("midreset_row", 32'(kp.row), 32'h E);
    check("midreset_code", 32'(kp.key_code), 32'd0);
    check("midreset_valid", 32'(kp.key_valid), 32'd0);
    check("midreset_held", 32'(kp.key_held), 32'd0);
    @(negedge CP);
    _CR = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      run_scan(16'h0080, v, h, k);
      check($sformatf("k7_post_s%0d_valid", s), 32'(v), 32'(s == 3));
      check($sformatf("k7_post_s%0d_code", s), 32'(k), (s == 3) ? 32'd7 : 32'd0);
    end
    for (int s = 0; s < 3; s++) run_scan(16'h0000, v, h, k);
    check("k7_released", 32'(h), 32'd0);

    // Randomized scans against the reference model.
    do_reset();
    model_reset();
    prev = '0;
    for (int s = 0; s < 80; s++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 5)      mask = prev;
      else if (sel < 7) mask = '0;
      else if (sel < 9) mask = 16'(1) << $urandom_range(0, 15);
      else              mask = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      prev = mask;
      model_step(mask, acc);
      run_scan(mask, v, h, k);
      check($sformatf("rnd%0d_valid", s), 32'(v), 32'(acc));
      check($sformatf("rnd%0d_held", s), 32'(h), 32'(m_held));
      check($sformatf("rnd%0d_code", s), 32'(k), 32'(m_code));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart of the clock's multiplexed 7-segment display driver. The display driver scans digit selects outward; this block scans a 4×4 matrix keypad inward. It drives one active-low row at a time, samples the active-low columns, debounces, and reports one key code per press. It sits beside the display driver on the `CP` domain and feeds alarm/time-set logic with clean single-cycle key events.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: `CP` cycles per row slot. Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans required to accept a press, and consecutive empty scans required to accept a release. Must be ≥ 1.

Ports:
- `CP`, input, 1: system clock. All state is on its rising edge.
- `_CR`, input, 1: reset, asynchronous, active-low.
- `col`, input, 4: keypad columns, active-low (pulled up externally), asynchronous to `CP`.
- `row`, output, 4: row drive, active-low, exactly one bit low at all times.
- `key_code`, output, 4: code of the last accepted key, `row_index*4 + col_index`.
- `key_valid`, output, 1: one-cycle pulse when a press is accepted.
- `key_held`, output, 1: high from acceptance until the release is accepted.

## Operation
- `col` passes through a 2-flop synchronizer; all logic uses the synchronized value `col_s`.
- Prescaler counts 0..SCAN_DIV-1. The final count is the slot tick.
- On the tick, the row index advances 0→1→2→3→0, and `row` is `~(4'b0001 << row_index)`.
- Sampling: on the tick, `col_s` is captured for the current row. The row has then been driven for SCAN_DIV-1 cycles, which covers the synchronizer delay.
- Per-scan accumulator: counts low columns and records the (row, col) of the last low bit seen.
- At the row-3 tick the scan is classified:
  - NONE: 0 keys.
  - SINGLE(k): exactly 1 key.
  - MULTI: 2 or more keys.
- After classification the accumulator clears.
- Debounce FSM, evaluated once per scan result:
  - IDLE:
    - SINGLE(k): go to CAND, set cand=k, cnt=1. If DEBOUNCE_SCANS==1, accept immediately (see PRESSED entry).
    - NONE or MULTI: stay in IDLE.
  - CAND:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_SCANS, go to PRESSED.
    - SINGLE(j≠cand): stay in CAND, set cand=j, cnt=1.
    - NONE or MULTI: go to IDLE.
  - PRESSED:
    - On entry: `key_code`←cand, pulse `key_valid`, set `key_held`=1, rel=0.
    - NONE: rel++. When rel reaches DEBOUNCE_SCANS, go to IDLE and set `key_held`=0.
    - SINGLE or MULTI (any key): rel=0. No rollover; a new key is not reported until a full release.
- `key_code` holds its value until the next acceptance.
- Counter widths: prescaler `$clog2(SCAN_DIV)`; cnt and rel `$clog2(DEBOUNCE_SCANS+1)`. They saturate and never wrap.

## Timing
- Reset values:
  - `row`=4'b1110 (row 0)
  - `key_code`=0, `key_valid`=0, `key_held`=0
  - FSM=IDLE
  - prescaler, accumulator, cnt, rel and synchronizer flops all cleared. Synchronizer flops reset to 1 (released).
- Full scan period is 4·SCAN_DIV cycles.
- `key_valid` is registered. It is high for exactly the one `CP` cycle after the row-3 tick that completes the debounce.
- `key_held` rises in the same cycle as `key_valid`. It falls the cycle after the row-3 tick of the DEBOUNCE_SCANS-th consecutive NONE scan.
- Minimum press-to-pulse latency is DEBOUNCE_SCANS full scans plus 1 cycle, measured from the first scan that sees the key in every slot.
- A `col` change inside a slot is only observed at that slot's tick. Glitches shorter than a slot between ticks are invisible.
- If `_CR` is asserted mid-scan or mid-debounce, everything returns to reset values immediately. No `key_valid` is emitted for the interrupted press. After release, a held key is re-debounced from IDLE.

## Structure
- Shared package `clock_pkg`:
  - scan-class enum (NONE, SINGLE, MULTI)
  - FSM state enum (IDLE, CAND, PRESSED)
  - constants `KP_ROWS=4`, `KP_COLS=4`
  - named key codes for the keys the alarm logic uses
- Sub-module `key_debounce`: the FSM plus cnt/rel counters. It takes a scan-class and code strobe and produces `key_code`, `key_valid` and `key_held`. The prescaler, row drive, synchronizer and accumulator stay in `keypad_scanner`.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=3 (scan=16 cycles).
- Reset idle, no keys:
  - `row` cycles 1110→1101→1011→0111, advancing every 4 cycles.
  - `key_valid` is never asserted; `key_held`=0.
- Key at row 2 / col 1 held for 5 scans:
  - `col`=4'b1101 only while row 2 is driven.
  - Exactly one `key_valid` pulse, after the 3rd scan, with `key_code`=9.
  - `key_held`=1 until 3 empty scans after release.
- Bounce: key 5 alternately present and absent on successive scans for 6 scans → no `key_valid`, FSM ends in IDLE.
- Rows 0 and 3 pressed simultaneously for 5 scans → classified MULTI each scan, no `key_valid`. Releasing row 3 leaves key 0 alone → `key_valid` after 3 more scans with `key_code`=0.
- While key 9 is held, also press key 4 and then release key 9 → no second pulse until all keys are released for 3 scans. A subsequent press of key 4 then yields `key_code`=4.
- `_CR` pulsed low during the 2nd debounce scan of key 7:
  - `row`=1110 and outputs are 0 immediately.
  - With the key still held, `key_valid` arrives 3 full scans plus 1 cycle after reset release.
